multi_write_fifo: RTL and testbench

Single-clock FIFO that accepts a variable number of entries per cycle (0..WR_PORTS lanes) and drains one entry per cycle. It supersedes the fixed two-entry-write FIFO used between extension stages and the collector. It adds true full/empty tracking, an occupancy count, an almost-full threshold, all-or-nothing group admission and a sticky overflow flag. Depth and lane count are parametrised.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_occupancy.sv | 62 ++++++
 rtl/multi_write_fifo.sv | 92 +++++++++
 tb/tb_multi_write_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-lane write FIFO: constant log2 and lane slicing.
package fifo_pkg;

  // Ceiling log2 for parameter arithmetic (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Low bit of lane idx in a packed bus of width-bit lanes; use as bus[lane_lo(i, W) +: W].
  function automatic int lane_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/fifo_occupancy.sv
// Occupancy tracking: count register, write/read admission, status decode and
// the sticky overflow flag. The write group is admitted all-or-nothing against
// the current count only; a same-cycle read frees no space for it.
module fifo_occupancy
  import fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int FIFO_DEPTH    = 1 << ADDRESS_WIDTH,
  parameter int WR_PORTS      = 2,
  parameter int AFULL_LEVEL   = FIFO_DEPTH - 4,
  parameter int CNT_W         = clog2(WR_PORTS + 1)
) (
  input  logic                   Clk,
  input  logic                   Clear_in,
  input  logic                   wr_en,
  input  logic [CNT_W-1:0]       wr_cnt,
  input  logic                   rd_en,
  output logic                   wr_acc,
  output logic                   rd_acc,
  output logic [ADDRESS_WIDTH:0] count,
  output logic                   full,
  output logic                   almost_full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int CW = ADDRESS_WIDTH + 1;

  logic [CW-1:0] cnt_ext;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] count_next;
  logic          wr_req;

  // Admission decisions and next occupancy from the registered count.
  always_comb begin
    cnt_ext    = CW'(wr_cnt);
    free_slots = CW'(FIFO_DEPTH) - count;
    wr_req     = wr_en && (wr_cnt != '0);
    // Counts above WR_PORTS are illegal and fall through as a rejection.
    wr_acc     = wr_req && (cnt_ext <= CW'(WR_PORTS)) && (cnt_ext <= free_slots);
    rd_acc     = rd_en && (count != '0);
    count_next = count + (wr_acc ? cnt_ext : '0) - (rd_acc ? CW'(1) : '0);
  end

  assign full        = free_slots < CW'(WR_PORTS);
  assign almost_full = count >= CW'(AFULL_LEVEL);
  assign empty       = count == '0;

  // Occupancy register and sticky record of any rejected write group.
  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_next;
      if (wr_req && !wr_acc) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_write_fifo.sv
// Single-clock FIFO taking 0..WR_PORTS entries per cycle (lane 0 oldest) and
// returning one entry per cycle with a registered, one-cycle-latency read.
module multi_write_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 65,
  parameter int ADDRESS_WIDTH = 4,
  parameter int FIFO_DEPTH    = 1 << ADDRESS_WIDTH,
  parameter int WR_PORTS      = 2,
  parameter int AFULL_LEVEL   = FIFO_DEPTH - 4,
  parameter int CNT_W         = clog2(WR_PORTS + 1)
) (
  input  logic                           Clk,
  input  logic                           Clear_in,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] Data_in,
  input  logic [CNT_W-1:0]               WriteCnt_in,
  input  logic                           WriteEn_in,
  output logic                           Full_out,
  output logic                           Almost_full_out,
  output logic                           Overflow_out,
  input  logic                           ReadEn_in,
  output logic [DATA_WIDTH-1:0]          Data_out,
  output logic                           Data_valid,
  output logic                           Empty_out,
  output logic [ADDRESS_WIDTH:0]         Count_out
);

  logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic                     wr_acc;
  logic                     rd_acc;

  fifo_occupancy #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .WR_PORTS      (WR_PORTS),
    .AFULL_LEVEL   (AFULL_LEVEL),
    .CNT_W         (CNT_W)
  ) u_occupancy (
    .Clk         (Clk),
    .Clear_in    (Clear_in),
    .wr_en       (WriteEn_in),
    .wr_cnt      (WriteCnt_in),
    .rd_en       (ReadEn_in),
    .wr_acc      (wr_acc),
    .rd_acc      (rd_acc),
    .count       (Count_out),
    .full        (Full_out),
    .almost_full (Almost_full_out),
    .empty       (Empty_out),
    .overflow    (Overflow_out)
  );

  // Storage: write the admitted lanes to consecutive slots; contents are never reset.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < WR_PORTS; i++) begin
      if (wr_acc && (CNT_W'(i) < WriteCnt_in)) begin
        mem[wr_ptr + ADDRESS_WIDTH'(i)] <= Data_in[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  // Pointers wrap naturally at FIFO_DEPTH; write pointer jumps by the group size.
  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDRESS_WIDTH'(WriteCnt_in);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Registered read port; Data_out holds between reads, Data_valid pulses once per read.
  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      Data_out   <= '0;
      Data_valid <= 1'b0;
    end else begin
      Data_valid <= rd_acc;
      if (rd_acc) begin
        Data_out <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_multi_write_fifo.sv
// Bench for multi_write_fifo: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the FIFO rules.
module tb_multi_write_fifo;

  localparam int DW    = 65;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int WR    = 2;
  localparam int AFULL = DEPTH - 4;
  localparam int CW    = 2;

  logic              Clk = 1'b0;
  logic              Clear_in;
  logic [WR*DW-1:0]  Data_in;
  logic [CW-1:0]     WriteCnt_in;
  logic              WriteEn_in;
  logic              Full_out;
  logic              Almost_full_out;
  logic              Overflow_out;
  logic              ReadEn_in;
  logic [DW-1:0]     Data_out;
  logic              Data_valid;
  logic              Empty_out;
  logic [AW:0]       Count_out;

  multi_write_fifo #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .WR_PORTS      (WR)
  ) dut (
    .Clk             (Clk),
    .Clear_in        (Clear_in),
    .Data_in         (Data_in),
    .WriteCnt_in     (WriteCnt_in),
    .WriteEn_in      (WriteEn_in),
    .Full_out        (Full_out),
    .Almost_full_out (Almost_full_out),
    .Overflow_out    (Overflow_out),
    .ReadEn_in       (ReadEn_in),
    .Data_out        (Data_out),
    .Data_valid      (Data_valid),
    .Empty_out       (Empty_out),
    .Count_out       (Count_out)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ovf;
  logic          last_acc;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd65();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_data   = '0;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    last_acc = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ":count"}, DW'(Count_out), DW'(sz));
    chk({tag, ":empty"}, DW'(Empty_out), DW'(sz == 0));
    chk({tag, ":full"},  DW'(Full_out),  DW'((DEPTH - sz) < WR));
    chk({tag, ":afull"}, DW'(Almost_full_out), DW'(sz >= AFULL));
    chk({tag, ":ovf"},   DW'(Overflow_out), DW'(m_ovf));
    chk({tag, ":valid"}, DW'(Data_valid), DW'(m_valid));
    chk({tag, ":data"},  Data_out, m_data);
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, then compare.
  task automatic step(input string tag, input logic we, input logic [CW-1:0] cnt,
                      input logic [WR*DW-1:0] d, input logic re);
    int  free;
    bit  acc;
    WriteEn_in  = we;
    WriteCnt_in = cnt;
    Data_in     = d;
    ReadEn_in   = re;
    free = DEPTH - mq.size();
    acc  = we && (cnt != 0) && (int'(cnt) <= WR) && (int'(cnt) <= free);
    m_valid = 1'b0;
    if (re && mq.size() != 0) begin
      m_data  = mq.pop_front();
      m_valid = 1'b1;
    end
    if (acc) begin
      for (int i = 0; i < int'(cnt); i++) mq.push_back(d[i*DW +: DW]);
    end else if (we && cnt != 0) begin
      m_ovf = 1'b1;
    end
    last_acc = acc;
    @(posedge Clk);
    #1;
    check_all(tag);
  endtask

  function automatic logic [WR*DW-1:0] pack2(input logic [DW-1:0] l1, input logic [DW-1:0] l0);
    return {l1, l0};
  endfunction

  initial begin
    logic [DW-1:0] a0, a1, b0, c0, c1;
    int wval, rexp, guard;
    logic [CW-1:0] c;

    Clear_in = 1'b1; WriteEn_in = 1'b0; WriteCnt_in = '0; ReadEn_in = 1'b0; Data_in = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_all("reset");
    Clear_in = 1'b0;

    // Reads on an empty FIFO produce nothing
    for (int i = 0; i < 3; i++) step("idle_rd", 1'b0, 2'd0, pack2(rnd65(), rnd65()), 1'b1);

    // Directed groups A, B, C then five reads
    a0 = rnd65(); a1 = rnd65(); b0 = rnd65(); c0 = rnd65(); c1 = rnd65();
    step("grpA", 1'b1, 2'd2, pack2(a1, a0), 1'b0);
    chk("grpA_cnt", DW'(Count_out), DW'(2));
    step("grpB", 1'b1, 2'd1, pack2(rnd65(), b0), 1'b0);
    chk("grpB_cnt", DW'(Count_out), DW'(3));
    step("grpC", 1'b1, 2'd2, pack2(c1, c0), 1'b0);
    chk("grpC_cnt", DW'(Count_out), DW'(5));
    step("rdA0", 1'b0, 2'd0, '0, 1'b1); chk("rdA0_val", Data_out, a0);
    step("rdA1", 1'b0, 2'd0, '0, 1'b1); chk("rdA1_val", Data_out, a1);
    step("rdB0", 1'b0, 2'd0, '0, 1'b1); chk("rdB0_val", Data_out, b0);
    step("rdC0", 1'b0, 2'd0, '0, 1'b1); chk("rdC0_val", Data_out, c0);
    step("rdC1", 1'b0, 2'd0, '0, 1'b1); chk("rdC1_val", Data_out, c1);
    chk("drained_empty", DW'(Empty_out), DW'(1));
    step("post_drain", 1'b0, 2'd0, '0, 1'b0);
    chk("valid_one_cycle", DW'(Data_valid), DW'(0));

    // Fill to 15, reject a pair, accept a single, then full read+write
    for (int i = 0; i < 7; i++) step("fill2", 1'b1, 2'd2, pack2(rnd65(), rnd65()), 1'b0);
    step("fill1", 1'b1, 2'd1, pack2(rnd65(), rnd65()), 1'b0);
    chk("c15_full", DW'(Full_out), DW'(1));
    chk("c15_afull", DW'(Almost_full_out), DW'(1));
    step("rej2", 1'b1, 2'd2, pack2(rnd65(), rnd65()), 1'b0);
    chk("rej2_cnt", DW'(Count_out), DW'(15));
    chk("rej2_ovf", DW'(Overflow_out), DW'(1));
    step("acc1", 1'b1, 2'd1, pack2(rnd65(), rnd65()), 1'b0);
    chk("acc1_cnt", DW'(Count_out), DW'(16));
    chk("acc1_ovf", DW'(Overflow_out), DW'(1));
    step("full_rw", 1'b1, 2'd1, pack2(rnd65(), rnd65()), 1'b1);
    chk("full_rw_cnt", DW'(Count_out), DW'(15));
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 2'd0, '0, 1'b1);

    // Wrap-around: values 0..39 in mixed group sizes with concurrent reads
    wval = 0; rexp = 0; guard = 0;
    while (rexp < 40 && guard < 500) begin
      guard++;
      c = (wval < 39) ? CW'($urandom_range(1, 2)) : 2'd1;
      step("wrap", wval < 40, c, pack2(DW'(wval + 1), DW'(wval)), ($urandom_range(0, 9) < 6));
      if (last_acc) wval += int'(c);
      chk("wrap_cnt_le16", DW'(Count_out <= 5'd16), DW'(1));
      if (Data_valid) begin
        chk("wrap_order", Data_out, DW'(rexp));
        rexp++;
      end
    end
    chk("wrap_all_read", DW'(rexp), DW'(40));

    // Randomized traffic including illegal counts
    for (int i = 0; i < 300; i++) begin
      step("rand", $urandom_range(0, 1), CW'($urandom_range(0, 3)),
           pack2(rnd65(), rnd65()), $urandom_range(0, 1));
    end

    // Mid-stream clear with 7 entries and a read in flight
    while (mq.size() != 0) step("pre_clr_drain", 1'b0, 2'd0, '0, 1'b1);
    step("illegal3", 1'b1, 2'd3, pack2(rnd65(), rnd65()), 1'b0);
    chk("illegal3_ovf", DW'(Overflow_out), DW'(1));
    for (int i = 0; i < 3; i++) step("pre7", 1'b1, 2'd2, pack2(rnd65(), rnd65()), 1'b0);
    step("pre7", 1'b1, 2'd1, pack2(rnd65(), rnd65()), 1'b0);
    chk("pre7_cnt", DW'(Count_out), DW'(7));
    WriteEn_in = 1'b0; ReadEn_in = 1'b1;
    #2;
    Clear_in = 1'b1;
    @(posedge Clk);
    #1;
    model_reset();
    check_all("clear");
    chk("clear_valid", DW'(Data_valid), DW'(0));
    chk("clear_ovf", DW'(Overflow_out), DW'(0));
    Clear_in = 1'b0;
    a0 = rnd65();
    step("post_clr_wr", 1'b1, 2'd1, pack2(rnd65(), a0), 1'b0);
    step("post_clr_rd", 1'b0, 2'd0, '0, 1'b1);
    chk("post_clr_data", Data_out, a0);
    step("post_clr_idle", 1'b0, 2'd0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
